// File: rtl/server_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : server_rx_monitor
// Purpose  : RX-side checker for the server test-traffic generator. Parses
//            header / timestamp / payload beats, validates each frame,
//            measures one-way latency and keeps per-port statistics.
// Revision : 1.0 - initial release
// ============================================================================
module server_rx_monitor #(
  parameter logic [47:0] P_MY_PORT_MAC = 48'h8D_BC_5C_4A_00_01,
  parameter logic [15:0] P_ETHERTYPE   = 16'h0800,
  parameter int unsigned P_PKT_LEN     = 128
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stat_rx_status,
  input  logic [63:0] i_time_stamp,
  input  logic        i_clear_stats,
  input  logic        rx_axis_tvalid,
  input  logic [63:0] rx_axis_tdata,
  input  logic        rx_axis_tlast,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tuser,
  output logic        rx_axis_tready,
  output logic        o_res_valid,
  output logic [47:0] o_res_src_mac,
  output logic [31:0] o_res_latency,
  output logic [3:0]  o_res_err,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_err_cnt,
  output logic [31:0] o_lat_min,
  output logic [31:0] o_lat_max
);

  localparam logic [15:0] LAST_IDX = 16'(P_PKT_LEN - 1);

  typedef enum logic [2:0] {
    S_HDR0    = 3'd0,
    S_HDR1    = 3'd1,
    S_TS      = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] beat_cnt, beat_cnt_nxt;
  logic [3:0]  err_q, err_cur;
  logic [47:0] src_q, src_nxt;
  logic [31:0] lat_q, lat_nxt;
  logic [63:0] ts_diff;
  logic        report;
  logic [31:0] good_cnt, err_cnt, lat_min, lat_max;

  assign rx_axis_tready = 1'b1;
  assign o_good_cnt     = good_cnt;
  assign o_err_cnt      = err_cnt;
  assign o_lat_min      = lat_min;
  assign o_lat_max      = lat_max;

  // Next-state logic: parse the accepted beat, accumulate sticky errors and
  // decide when the frame is reported. err_cur/src_nxt/lat_nxt already include
  // the current beat so a report can use them directly.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    err_cur      = err_q;
    src_nxt      = src_q;
    lat_nxt      = lat_q;
    report       = 1'b0;
    ts_diff      = i_time_stamp - rx_axis_tdata;

    if (!i_stat_rx_status) begin
      // Link down: drop any partial frame silently.
      state_nxt    = S_HDR0;
      beat_cnt_nxt = 16'd0;
    end else if (rx_axis_tvalid) begin
      // Errors are sticky inside a frame; beat 0 starts from a clean slate.
      err_cur      = (state == S_HDR0) ? 4'b0000 : err_q;
      beat_cnt_nxt = beat_cnt + 16'd1;
      if (rx_axis_tuser || (rx_axis_tkeep != 8'hFF)) err_cur[3] = 1'b1;

      case (state)
        S_HDR0: begin
          src_nxt   = {rx_axis_tdata[15:0], 32'h0};
          lat_nxt   = 32'h0;
          if (rx_axis_tdata[63:16] != P_MY_PORT_MAC) err_cur[0] = 1'b1;
          state_nxt = S_HDR1;
        end
        S_HDR1: begin
          src_nxt[31:0] = rx_axis_tdata[63:32];
          if (rx_axis_tdata[31:16] != P_ETHERTYPE) err_cur[1] = 1'b1;
          state_nxt = S_TS;
        end
        S_TS: begin
          lat_nxt   = (ts_diff[63:32] != 32'h0) ? 32'hFFFF_FFFF : ts_diff[31:0];
          state_nxt = S_PAYLOAD;
        end
        S_PAYLOAD: state_nxt = S_PAYLOAD;
        S_DROP:    beat_cnt_nxt = beat_cnt;
        default:   state_nxt = S_HDR0;
      endcase

      if (state == S_DROP) begin
        if (rx_axis_tlast) begin
          report       = 1'b1;
          state_nxt    = S_HDR0;
          beat_cnt_nxt = 16'd0;
        end
      end else if (rx_axis_tlast) begin
        if (beat_cnt != LAST_IDX) err_cur[2] = 1'b1;
        report       = 1'b1;
        state_nxt    = S_HDR0;
        beat_cnt_nxt = 16'd0;
      end else if (beat_cnt == LAST_IDX) begin
        // Frame overran its length: flag it and swallow beats until tlast.
        err_cur[2] = 1'b1;
        state_nxt  = S_DROP;
      end
    end
  end

  // Frame-parsing state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_HDR0;
      beat_cnt <= 16'd0;
      err_q    <= 4'b0000;
      src_q    <= 48'h0;
      lat_q    <= 32'h0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      err_q    <= err_cur;
      src_q    <= src_nxt;
      lat_q    <= lat_nxt;
    end
  end

  // Per-frame result registers; hold until the next report.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res_valid   <= 1'b0;
      o_res_src_mac <= 48'h0;
      o_res_latency <= 32'h0;
      o_res_err     <= 4'b0000;
    end else begin
      o_res_valid <= report;
      if (report) begin
        o_res_src_mac <= src_nxt;
        o_res_latency <= lat_nxt;
        o_res_err     <= err_cur;
      end
    end
  end

  // Statistics: update alongside o_res_valid; a clear overrides the report.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear_stats) begin
      good_cnt <= 32'h0;
      err_cnt  <= 32'h0;
      lat_min  <= 32'hFFFF_FFFF;
      lat_max  <= 32'h0;
    end else if (report) begin
      if (err_cur == 4'b0000) begin
        if (good_cnt != 32'hFFFF_FFFF) good_cnt <= good_cnt + 32'd1;
        if (lat_nxt < lat_min) lat_min <= lat_nxt;
        if (lat_nxt > lat_max) lat_max <= lat_nxt;
      end else if (err_cnt != 32'hFFFF_FFFF) begin
        err_cnt <= err_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire
